// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake/bus bundle between fetch, the fetch queue and decode.
//   in_valid/in_pc/in_instr/in_ready : fetch -> queue push channel
//   out_valid/out_pc/out_instr/out_ready : queue -> decode pop channel
//   flush : discard every buffered entry
//   count : current occupancy, 0..DEPTH
// modport slave is the queue side; modport master is the fetch/decode side.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_ready;
  logic          flush;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer between fetch and decode.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears pointers, count and storage
//   fq    : fetch_queue_if.slave (push channel, pop channel, flush, count)
// Every output is a function of registered state only, so no input reaches
// an output combinationally. Flush wins over push and pop in the same cycle.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  fetch_queue_if.slave fq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic full, empty, push, pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Handshakes are qualified with registered flags, so a pop in the same
  // cycle never opens a slot for a push while full.
  assign push = fq.in_valid  & ~full  & ~fq.flush;
  assign pop  = fq.out_ready & ~empty & ~fq.flush;

  assign fq.in_ready  = ~full;
  assign fq.out_valid = ~empty;
  assign fq.count     = count_q;
  assign fq.out_pc    = empty ? '0 : mem_q[head_q].pc;
  assign fq.out_instr = empty ? '0 : mem_q[head_q].instr;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (fq.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage survives flush; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[tail_q] <= '{pc: fq.in_pc, instr: fq.in_instr};
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'hbfc00000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) fq ();
  fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .fq(fq));

  int checks = 0;
  int errors = 0;
  int mcount = 0;
  logic [31:0] sb_pc [$];
  logic [31:0] sb_in [$];
  logic [31:0] nxt_pc;

  function automatic logic [31:0] mk_ins(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h0000_0013;
  endfunction

  // Drive one cycle: apply inputs, update the reference model, pass the edge.
  task automatic cyc(input bit iv, input logic [31:0] pc, input bit ordy, input bit fl);
    bit do_push, do_pop;
    fq.in_valid  = iv;
    fq.in_pc     = pc;
    fq.in_instr  = mk_ins(pc);
    fq.out_ready = ordy;
    fq.flush     = fl;
    do_push = iv && (mcount < DEPTH) && !fl;
    do_pop  = ordy && (mcount > 0) && !fl;
    if (fl) begin
      sb_pc.delete(); sb_in.delete(); mcount = 0;
    end else begin
      if (do_pop)  begin void'(sb_pc.pop_front()); void'(sb_in.pop_front()); mcount--; end
      if (do_push) begin sb_pc.push_back(pc); sb_in.push_back(mk_ins(pc)); mcount++; end
    end
    @(posedge clk);
    #1;
    fq.in_valid = 1'b0; fq.out_ready = 1'b0; fq.flush = 1'b0;
  endtask

  task automatic test_reset();
    fq.in_valid = 0; fq.in_pc = '0; fq.in_instr = '0; fq.out_ready = 0; fq.flush = 0;
    #12;
    checks++;
    if (fq.out_valid !== 1'b0 || fq.in_ready !== 1'b1 || fq.count !== 3'd0 || fq.out_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_init: ov=%b ir=%b cnt=%0d pc=%h want 0/1/0/0", fq.out_valid, fq.in_ready, fq.count, fq.out_pc);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1, 32'h1000 + 32'(i*4), 0, 0);
    checks++;
    if (fq.count !== 3'd3) begin errors++; $display("FAIL reset_precount: got %0d want 3", fq.count); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (fq.out_valid !== 1'b0 || fq.in_ready !== 1'b1 || fq.count !== 3'd0 || fq.out_pc !== 32'h0 || fq.out_instr !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: ov=%b ir=%b cnt=%0d pc=%h in=%h want 0/1/0/0/0", fq.out_valid, fq.in_ready, fq.count, fq.out_pc, fq.out_instr);
    end
    sb_pc.delete(); sb_in.delete(); mcount = 0;
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, BASE + 32'(i*4), 0, 0);
      checks++;
      if (fq.count !== 3'(i+1) || fq.out_valid !== 1'b1) begin
        errors++; $display("FAIL fill_count[%0d]: got %0d ov=%b want %0d ov=1", i, fq.count, fq.out_valid, i+1);
      end
    end
    checks++;
    if (fq.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b want 0", fq.in_ready); end
    for (int i = 0; i < 2; i++) begin
      cyc(1, BASE + 32'h10, 0, 0);
      checks++;
      if (fq.count !== 3'd4 || fq.in_ready !== 1'b0) begin
        errors++; $display("FAIL fill_overflow[%0d]: cnt=%0d ir=%b want 4/0", i, fq.count, fq.in_ready);
      end
    end
  endtask

  task automatic test_drain(input string tag);
    int n;
    n = mcount;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (fq.out_valid !== 1'b1 || fq.out_pc !== sb_pc[0] || fq.out_instr !== sb_in[0]) begin
        errors++;
        $display("FAIL %s_data[%0d]: ov=%b pc=%h in=%h want 1/%h/%h", tag, i, fq.out_valid, fq.out_pc, fq.out_instr, sb_pc[0], sb_in[0]);
      end
      cyc(0, '0, 1, 0);
    end
    checks++;
    if (fq.out_valid !== 1'b0 || fq.out_pc !== 32'h0 || fq.count !== 3'd0 || fq.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_empty: ov=%b pc=%h cnt=%0d ir=%b want 0/0/0/1", tag, fq.out_valid, fq.out_pc, fq.count, fq.in_ready);
    end
  endtask

  task automatic test_stream();
    nxt_pc = BASE + 32'h200;
    cyc(1, nxt_pc, 0, 0);
    nxt_pc += 4;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (fq.out_pc !== sb_pc[0] || fq.out_instr !== sb_in[0]) begin
        errors++;
        $display("FAIL stream_data[%0d]: pc=%h in=%h want %h/%h", i, fq.out_pc, fq.out_instr, sb_pc[0], sb_in[0]);
      end
      cyc(1, nxt_pc, 1, 0);
      nxt_pc += 4;
      checks++;
      if (fq.count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d]: got %0d want 1", i, fq.count); end
    end
    test_drain("stream_drain");
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < DEPTH; i++) cyc(1, BASE + 32'h300 + 32'(i*4), 0, 0);
    checks++;
    if (fq.out_pc !== sb_pc[0]) begin errors++; $display("FAIL fullpp_head: got %h want %h", fq.out_pc, sb_pc[0]); end
    cyc(1, BASE + 32'h310, 1, 0);
    checks++;
    if (fq.count !== 3'd3 || fq.in_ready !== 1'b1) begin
      errors++; $display("FAIL fullpp_pop_only: cnt=%0d ir=%b want 3/1", fq.count, fq.in_ready);
    end
    cyc(1, BASE + 32'h310, 0, 0);
    checks++;
    if (fq.count !== 3'd4) begin errors++; $display("FAIL fullpp_accept: got %0d want 4", fq.count); end
    test_drain("fullpp_drain");
  endtask

  task automatic test_flush();
    cyc(1, BASE + 32'h400, 0, 0);
    cyc(1, BASE + 32'h404, 0, 0);
    checks++;
    if (fq.count !== 3'd2) begin errors++; $display("FAIL flush_pre: got %0d want 2", fq.count); end
    cyc(1, BASE + 32'h100, 1, 1);
    checks++;
    if (fq.count !== 3'd0 || fq.out_valid !== 1'b0 || fq.in_ready !== 1'b1 || fq.out_pc !== 32'h0) begin
      errors++;
      $display("FAIL flush_clear: cnt=%0d ov=%b ir=%b pc=%h want 0/0/1/0", fq.count, fq.out_valid, fq.in_ready, fq.out_pc);
    end
    cyc(1, BASE + 32'h100, 0, 0);
    checks++;
    if (fq.count !== 3'd1 || fq.out_pc !== 32'hbfc00100 || fq.out_instr !== mk_ins(32'hbfc00100)) begin
      errors++;
      $display("FAIL flush_repush: cnt=%0d pc=%h in=%h want 1/bfc00100/%h", fq.count, fq.out_pc, fq.out_instr, mk_ins(32'hbfc00100));
    end
    test_drain("flush_drain");
  endtask

  task automatic test_back_to_back();
    // Random push/pop mix, checking every pop against the scoreboard.
    for (int i = 0; i < 60; i++) begin
      bit iv, ordy;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      if (ordy && mcount > 0) begin
        checks++;
        if (fq.out_pc !== sb_pc[0] || fq.out_instr !== sb_in[0]) begin
          errors++;
          $display("FAIL b2b_data[%0d]: pc=%h in=%h want %h/%h", i, fq.out_pc, fq.out_instr, sb_pc[0], sb_in[0]);
        end
      end
      cyc(iv, BASE + 32'h800 + 32'(i*4), ordy, 0);
      checks++;
      if (fq.count !== 3'(mcount)) begin errors++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, fq.count, mcount); end
    end
    test_drain("b2b_drain");
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_drain("drain");
    test_stream();
    test_full_pushpop();
    test_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
